// File: rtl/usb_pkg.sv
// ---------------------------------------------------------------------------
// usb_pkg
// Shared definitions for the receive-side packet blocks:
//   - data_sel class encodings (shared with the transmit-side combiner)
//   - byte counts of the three legal packet shapes
//   - receive FSM state enum
//   - cntInc: saturating increment for the assembly byte counter
// ---------------------------------------------------------------------------
package usb_pkg;

    localparam logic [2:0] SEL_HANDSHAKE = 3'b010;
    localparam logic [2:0] SEL_TOKEN     = 3'b011;
    localparam logic [2:0] SEL_DATA      = 3'b001;
    localparam logic [2:0] SEL_NONE      = 3'b100;

    localparam logic [3:0] CNT_HANDSHAKE = 4'd1;
    localparam logic [3:0] CNT_TOKEN     = 4'd3;
    localparam logic [3:0] CNT_DATA      = 4'd11;
    localparam logic [3:0] CNT_MAX       = 4'd12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // The counter stops at CNT_MAX so an over-long packet cannot wrap
    // back into a legal length.
    function automatic logic [3:0] cntInc(input logic [3:0] c);
        return (c >= CNT_MAX) ? CNT_MAX : c + 4'd1;
    endfunction

endpackage

// File: rtl/pid_check.sv
// ---------------------------------------------------------------------------
// pid_check
// Combinational PID integrity check: a PID is well formed when its upper
// nibble is the bitwise complement of its lower nibble.
// Ports:
//   pid     in  8  PID byte to check
//   pid_ok  out 1  high when the PID is well formed
// ---------------------------------------------------------------------------
module pid_check (
    input  logic [7:0] pid,
    output logic       pid_ok
);

    assign pid_ok = (pid[7:4] == ~pid[3:0]);

endmodule

// File: rtl/packet_split.sv
// ---------------------------------------------------------------------------
// packet_split
// Receive-side packet disassembler. Collects decoded bytes (PID first, LSB
// byte first) into an 88-bit assembly register, classifies the packet by
// its byte count on eop, and presents PID / data / CRC fields with the
// same data_sel encoding as the transmit path.
// Optional build macro:
//   PID_CHECK_EN  when defined, a packet whose PID fails the nibble
//                 complement check is discarded as an error.
// Ports:
//   clk        in  1   system clock
//   rst        in  1   synchronous active-high reset
//   rx_byte    in  8   received byte
//   byte_valid in  1   rx_byte valid this cycle
//   eop        in  1   end-of-packet strobe (may coincide with last byte)
//   rx_error   in  1   receiver error in the current packet
//   PID_out    out 8   captured PID
//   data_out   out 64  captured data payload
//   CRC_out    out 16  captured CRC field (token body for tokens)
//   data_sel   out 3   packet class (010 hs, 011 token, 001 data, 100 none)
//   pkt_valid  out 1   one-cycle pulse: good packet committed
//   pkt_err    out 1   one-cycle pulse: packet discarded
//   busy       out 1   packet in progress
// ---------------------------------------------------------------------------
module packet_split
    import usb_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_byte,
    input  logic        byte_valid,
    input  logic        eop,
    input  logic        rx_error,
    output logic [7:0]  PID_out,
    output logic [63:0] data_out,
    output logic [15:0] CRC_out,
    output logic [2:0]  data_sel,
    output logic        pkt_valid,
    output logic        pkt_err,
    output logic        busy
);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [87:0] asm_q, asm_d;
    logic [7:0]  pid_q, pid_d;
    logic [63:0] data_q, data_d;
    logic [15:0] crc_q, crc_d;
    logic [2:0]  sel_q, sel_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;

    logic        takeByte;
    logic [87:0] asmIn;
    logic [3:0]  cntIn;
    logic        atEop;
    logic        pidOk;

    // Assembly view that already includes this cycle's byte, so a byte
    // arriving together with eop is part of the evaluated packet. Bytes
    // beyond the 11th only advance the counter.
    always_comb begin
        takeByte = byte_valid && (state_q != DRAIN);
        asmIn    = asm_q;
        cntIn    = cnt_q;
        if (takeByte) begin
            if (cnt_q < CNT_DATA) begin
                asmIn[{cnt_q, 3'b000} +: 8] = rx_byte;
            end
            cntIn = cntInc(cnt_q);
        end
    end

`ifdef PID_CHECK_EN
    pid_check uPidCheck (
        .pid    (asmIn[7:0]),
        .pid_ok (pidOk)
    );
`else
    assign pidOk = 1'b1;
`endif

    // eop only means something once a packet has started; in IDLE it
    // counts only when it arrives together with the PID byte.
    assign atEop = eop && ((state_q != IDLE) || byte_valid);

    // Next-state and output-register logic. Fields hold unless a good
    // packet is committed; an error only touches data_sel and pkt_err.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        asm_d   = asm_q;
        pid_d   = pid_q;
        data_d  = data_q;
        crc_d   = crc_q;
        sel_d   = sel_q;
        valid_d = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (byte_valid) begin
                    asm_d   = asmIn;
                    cnt_d   = cntIn;
                    state_d = rx_error ? DRAIN : RECV;
                end
            end
            RECV: begin
                asm_d = asmIn;
                cnt_d = cntIn;
                if (rx_error || (cntIn == CNT_MAX)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d = DRAIN;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (atEop) begin
            state_d = IDLE;
            asm_d   = '0;
            cnt_d   = '0;
            if ((state_q == DRAIN) || rx_error || !pidOk) begin
                err_d = 1'b1;
                sel_d = SEL_NONE;
            end else begin
                case (cntIn)
                    CNT_HANDSHAKE: begin
                        pid_d   = asmIn[7:0];
                        data_d  = '0;
                        crc_d   = '0;
                        sel_d   = SEL_HANDSHAKE;
                        valid_d = 1'b1;
                    end
                    CNT_TOKEN: begin
                        pid_d   = asmIn[7:0];
                        data_d  = '0;
                        crc_d   = asmIn[23:8];
                        sel_d   = SEL_TOKEN;
                        valid_d = 1'b1;
                    end
                    CNT_DATA: begin
                        pid_d   = asmIn[7:0];
                        data_d  = asmIn[71:8];
                        crc_d   = asmIn[87:72];
                        sel_d   = SEL_DATA;
                        valid_d = 1'b1;
                    end
                    default: begin
                        err_d = 1'b1;
                        sel_d = SEL_NONE;
                    end
                endcase
            end
        end
    end

    // State and output registers; reset drops any partial packet silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            asm_q   <= '0;
            pid_q   <= '0;
            data_q  <= '0;
            crc_q   <= '0;
            sel_q   <= SEL_NONE;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            asm_q   <= asm_d;
            pid_q   <= pid_d;
            data_q  <= data_d;
            crc_q   <= crc_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign PID_out   = pid_q;
    assign data_out  = data_q;
    assign CRC_out   = crc_q;
    assign data_sel  = sel_q;
    assign pkt_valid = valid_q;
    assign pkt_err   = err_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_packet_split.sv
// ---------------------------------------------------------------------------
// tb_packet_split
// Directed and randomized stimulus for packet_split. A packet-level model
// keeps the bytes of the packet in flight in a queue and decides the
// outcome on eop from the byte count and error flags.
// ---------------------------------------------------------------------------
module tb_packet_split;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_byte;
    logic        byte_valid;
    logic        eop;
    logic        rx_error;
    logic [7:0]  PID_out;
    logic [63:0] data_out;
    logic [15:0] CRC_out;
    logic [2:0]  data_sel;
    logic        pkt_valid;
    logic        pkt_err;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    // Packet-level reference model state
    logic [7:0]  pkt[$];
    bit          inPkt;
    bit          bad;
    logic [7:0]  expPid;
    logic [63:0] expData;
    logic [15:0] expCrc;
    logic [2:0]  expSel;
    logic        expValid;
    logic        expErr;
    logic        expBusy;

    logic [7:0]  txBytes[$];

    always #5 clk = ~clk;

    packet_split dut (
        .clk        (clk),
        .rst        (rst),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .eop        (eop),
        .rx_error   (rx_error),
        .PID_out    (PID_out),
        .data_out   (data_out),
        .CRC_out    (CRC_out),
        .data_sel   (data_sel),
        .pkt_valid  (pkt_valid),
        .pkt_err    (pkt_err),
        .busy       (busy)
    );

    task automatic checkField(input string tag, input string name,
                              input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("[TB] FAIL %s/%s: observed %h expected %h", tag, name, got, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkField(tag, "PID_out",   {56'd0, PID_out},   {56'd0, expPid});
        checkField(tag, "data_out",  data_out,           expData);
        checkField(tag, "CRC_out",   {48'd0, CRC_out},   {48'd0, expCrc});
        checkField(tag, "data_sel",  {61'd0, data_sel},  {61'd0, expSel});
        checkField(tag, "pkt_valid", {63'd0, pkt_valid}, {63'd0, expValid});
        checkField(tag, "pkt_err",   {63'd0, pkt_err},   {63'd0, expErr});
        checkField(tag, "busy",      {63'd0, busy},      {63'd0, expBusy});
    endtask

    task automatic modelReset();
        pkt.delete();
        inPkt    = 0;
        bad      = 0;
        expPid   = 8'h00;
        expData  = 64'h0;
        expCrc   = 16'h0;
        expSel   = 3'b100;
        expValid = 1'b0;
        expErr   = 1'b0;
        expBusy  = 1'b0;
    endtask

    // Decide the fate of the finished packet from its byte list.
    task automatic modelEvaluate();
        bit         ok;
        logic [7:0] p;
        int         n;
        n  = pkt.size();
        p  = pkt[0];
        ok = !bad && (n == 1 || n == 3 || n == 11);
`ifdef PID_CHECK_EN
        if (p[7:4] != ~p[3:0]) ok = 0;
`endif
        if (ok) begin
            expPid   = p;
            expValid = 1'b1;
            if (n == 1) begin
                expData = 64'h0;
                expCrc  = 16'h0;
                expSel  = 3'b010;
            end else if (n == 3) begin
                expData = 64'h0;
                expCrc  = {pkt[2], pkt[1]};
                expSel  = 3'b011;
            end else begin
                expData = 64'h0;
                for (int i = 1; i <= 8; i++) expData = expData | (64'(pkt[i]) << (8 * (i - 1)));
                expCrc  = {pkt[10], pkt[9]};
                expSel  = 3'b001;
            end
        end else begin
            expErr = 1'b1;
            expSel = 3'b100;
        end
        pkt.delete();
        inPkt = 0;
        bad   = 0;
    endtask

    task automatic modelCycle(input logic r, input logic bv, input logic [7:0] b,
                              input logic e, input logic re);
        expValid = 1'b0;
        expErr   = 1'b0;
        if (r) begin
            modelReset();
            return;
        end
        if (!inPkt) begin
            if (bv) begin
                pkt.delete();
                pkt.push_back(b);
                bad   = re;
                inPkt = 1;
            end
        end else begin
            if (bv && !bad) pkt.push_back(b);
            if (re) bad = 1;
            if (pkt.size() >= 12) bad = 1;
        end
        if (inPkt && e) modelEvaluate();
        expBusy = inPkt;
    endtask

    // Drive one cycle of inputs (at a falling edge), advance the model, and
    // check the DUT at the next falling edge.
    task automatic applyStimulus(input string tag, input logic r, input logic bv,
                                 input logic [7:0] b, input logic e, input logic re);
        rst        = r;
        byte_valid = bv;
        rx_byte    = b;
        eop        = e;
        rx_error   = re;
        modelCycle(r, bv, b, e, re);
        @(negedge clk);
        checkOutput(tag);
    endtask

    // Send txBytes as one packet; errIdx < 0 means no rx_error.
    task automatic sendPacket(input string tag, input int errIdx,
                              input bit eopLast, input int gapMax);
        int last;
        last = txBytes.size() - 1;
        for (int i = 0; i <= last; i++) begin
            if (gapMax > 0) begin
                repeat ($urandom_range(gapMax, 0)) applyStimulus(tag, 0, 0, 8'h00, 0, 0);
            end
            applyStimulus(tag, 0, 1, txBytes[i], eopLast && (i == last), i == errIdx);
        end
        if (!eopLast) applyStimulus(tag, 0, 0, 8'h00, 1, 0);
    endtask

    initial begin
        logic [3:0] nib;
        int         kind;
        int         len;
        int         errIdx;
        bit         eopLast;

        rst        = 1'b1;
        byte_valid = 1'b0;
        rx_byte    = 8'h00;
        eop        = 1'b0;
        rx_error   = 1'b0;
        modelReset();
        @(negedge clk);

        $display("[TB] reset");
        applyStimulus("reset", 1, 0, 8'h00, 0, 0);
        applyStimulus("reset", 1, 0, 8'h00, 0, 0);
        applyStimulus("idle", 0, 0, 8'h00, 0, 0);
        applyStimulus("eop_idle", 0, 0, 8'h00, 1, 0);

        $display("[TB] handshake");
        applyStimulus("handshake", 0, 1, 8'hD2, 1, 0);
        applyStimulus("handshake", 0, 0, 8'h00, 0, 0);

        $display("[TB] token");
        txBytes = '{8'h69, 8'h34, 8'h12};
        sendPacket("token", -1, 0, 0);

        $display("[TB] data");
        txBytes = '{8'hC3, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                    8'h08, 8'hEF, 8'hBE};
        sendPacket("data", -1, 0, 0);
        applyStimulus("data", 0, 0, 8'h00, 0, 0);

        $display("[TB] error packets");
        txBytes = '{8'hA5, 8'h11};
        sendPacket("short", -1, 0, 0);
        txBytes.delete();
        for (int i = 0; i < 13; i++) txBytes.push_back(8'(8'h30 + i));
        sendPacket("long13", -1, 0, 0);
        applyStimulus("long13", 0, 0, 8'h00, 0, 0);
        txBytes = '{8'hC3, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77,
                    8'h88, 8'h99, 8'hAA};
        sendPacket("rxerr", 2, 0, 0);
        txBytes = '{8'h4B, 8'h10, 8'h20};
        sendPacket("rxerr_eop", 2, 1, 0);

        $display("[TB] pid integrity");
        applyStimulus("pid_d3", 0, 1, 8'hD3, 1, 0);
        applyStimulus("pid_d3", 0, 0, 8'h00, 0, 0);

        $display("[TB] back to back");
        txBytes = '{8'hC3, 8'hF1, 8'hF2, 8'hF3, 8'hF4, 8'hF5, 8'hF6, 8'hF7,
                    8'hF8, 8'h0D, 8'hF0};
        sendPacket("b2b_data", -1, 0, 0);
        txBytes = '{8'hE1, 8'hCD, 8'hAB};
        sendPacket("b2b_token", -1, 1, 0);
        applyStimulus("b2b_token", 0, 0, 8'h00, 0, 0);

        $display("[TB] reset mid packet");
        for (int i = 0; i < 5; i++) applyStimulus("rst_mid", 0, 1, 8'(8'h50 + i), 0, 0);
        applyStimulus("rst_mid", 1, 0, 8'h00, 0, 0);
        applyStimulus("rst_mid", 0, 0, 8'h00, 0, 0);
        applyStimulus("rst_mid", 0, 0, 8'h00, 1, 0);
        applyStimulus("rst_eop", 0, 1, 8'h69, 0, 0);
        applyStimulus("rst_eop", 0, 1, 8'h01, 0, 0);
        applyStimulus("rst_eop", 1, 1, 8'h02, 1, 0);
        applyStimulus("rst_eop", 0, 0, 8'h00, 0, 0);

        $display("[TB] random packets");
        for (int n = 0; n < 60; n++) begin
            kind = int'($urandom_range(3, 0));
            case (kind)
                0:       len = 1;
                1:       len = 3;
                2:       len = 11;
                default: len = int'($urandom_range(14, 1));
            endcase
            txBytes.delete();
            if ($urandom_range(3, 0) != 0) begin
                nib = 4'($urandom_range(15, 0));
                txBytes.push_back({~nib, nib});
            end else begin
                txBytes.push_back(8'($urandom_range(255, 0)));
            end
            for (int i = 1; i < len; i++) txBytes.push_back(8'($urandom_range(255, 0)));
            errIdx  = ($urandom_range(9, 0) == 0) ? int'($urandom_range(len - 1, 0)) : -1;
            eopLast = ($urandom_range(1, 0) == 1);
            sendPacket("random", errIdx, eopLast, ($urandom_range(1, 0) == 1) ? 2 : 0);
            repeat ($urandom_range(2, 0)) begin
                applyStimulus("random_gap", 0, 0, 8'h00, 1'($urandom_range(1, 0)), 0);
            end
        end
        applyStimulus("final", 0, 0, 8'h00, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/packet_split.md
# packet_split

Receive-side packet disassembler, the inverse of the transmit-side packet combiner. Accepts decoded bytes from the bit-level receiver (least significant byte first, PID first), assembles them, classifies the packet by length, and presents PID, 64-bit data and 16-bit CRC fields in the same layout and `data_sel` encoding the transmit path uses. It sits between the byte receiver and the decrypt/CRC-check stage.

## Interface

- No parameters.
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `rx_byte`  in  8  received byte
- `byte_valid`  in  1  `rx_byte` valid this cycle
- `eop`  in  1  end-of-packet strobe
  - May coincide with the last `byte_valid`.
- `rx_error`  in  1  receiver error (bit-stuff or sync) in the current packet
- `PID_out`  out  8  captured PID
- `data_out`  out  64  captured data payload
- `CRC_out`  out  16  captured CRC field
  - For tokens, this field holds the 16-bit token body.
- `data_sel`  out  3  packet class
  - 3'b010: handshake.
  - 3'b011: token.
  - 3'b001: data.
  - 3'b100: none.
- `pkt_valid`  out  1  one-cycle pulse: good packet committed
- `pkt_err`  out  1  one-cycle pulse: packet discarded
- `busy`  out  1  packet in progress (state != IDLE)

## Operation

- **Assembly register.**
  - 88-bit assembly register `asm` and 4-bit byte counter `cnt`, saturating at 12.
  - An accepted byte is written to `asm[8*cnt +: 8]`, then `cnt` increments.
- **IDLE.**
  - `cnt` = 0 and `asm` is cleared.
  - A `byte_valid` is accepted as the PID and the state moves to RECV.
  - `eop` with no bytes is ignored.
- **RECV.**
  - Bytes are accepted.
  - If `rx_error` is asserted, or a 12th byte arrives, go to DRAIN.
- **DRAIN.**
  - Bytes are ignored until `eop`.
- **Evaluation on `eop`** in RECV or DRAIN. The final byte, if any, is included first.
  - `cnt`=1 → handshake:
    - `PID_out` = `asm[7:0]`
    - `data_out`, `CRC_out` = 0
    - `data_sel` = 010
  - `cnt`=3 → token:
    - `PID_out` = `asm[7:0]`
    - `CRC_out` = `asm[23:8]`
    - `data_out` = 0
    - `data_sel` = 011
  - `cnt`=11 → data:
    - `PID_out` = `asm[7:0]`
    - `data_out` = `asm[71:8]`
    - `CRC_out` = `asm[87:72]`
    - `data_sel` = 001
  - Any other count, DRAIN, or `rx_error` in the `eop` cycle → error.
- **Good packet.** Output fields are committed and `pkt_valid` pulses.
- **Error.**
  - `pkt_err` pulses.
  - `PID_out`, `data_out` and `CRC_out` keep their previous values.
  - `data_sel` becomes 100.
- **Return to IDLE.** Always after `eop` evaluation.
  - A `byte_valid` in the cycle after `eop` begins the next packet.
- **Overlap.** `pkt_valid` and `pkt_err` are never asserted together.

## Timing

- **Reset values.**
  - `PID_out` = 0, `data_out` = 0, `CRC_out` = 0.
  - `data_sel` = 3'b100.
  - `pkt_valid` = 0, `pkt_err` = 0, `busy` = 0.
  - State IDLE, `cnt` = 0.
- **Latency.** `pkt_valid`/`pkt_err` assert in the cycle after `eop` is sampled.
  - Fields and `data_sel` update on the same edge and hold until the next evaluation.
- **Throughput.** One byte per cycle maximum. No backpressure.
- **`rst` mid-packet.** The partial packet is dropped without a `pkt_err`, and all outputs return to their reset values.
- **`rst` and `eop` together.** Reset wins.

## Configuration

- **`PID_CHECK_EN` defined.** At evaluation, a packet is also an error unless `asm[7:4]` == ~`asm[3:0]`.
- **`PID_CHECK_EN` not defined.** PID integrity is not checked; only length and `rx_error` decide validity.

## Structure

- **Shared package `usb_pkg`.**
  - `data_sel` encodings: `SEL_HANDSHAKE`=3'b010, `SEL_TOKEN`=3'b011, `SEL_DATA`=3'b001, `SEL_NONE`=3'b100.
  - Byte counts: 1, 3, 11.
  - State enum: IDLE/RECV/DRAIN.
- **Sub-module `pid_check`.**
  - Combinational, 8-bit input, 1-bit `pid_ok`.
  - Instantiated only under `PID_CHECK_EN`.
  - Reused by other receive-side blocks.

## Test plan

1. **Handshake.** Byte 0xD2 with `eop` in the same cycle → next cycle `pkt_valid`=1, `data_sel`=010, `PID_out`=0xD2.
2. **Token.** Bytes 0x69, 0x34, 0x12, then `eop` → `data_sel`=011, `CRC_out`=0x1234, `data_out`=0.
3. **Data.** Bytes 0xC3, 0x01…0x08, 0xEF, 0xBE, then `eop` → `data_sel`=001, `data_out`=0x0807060504030201, `CRC_out`=0xBEEF.
4. **Errors.**
   - 2-byte packet → `pkt_err`, previous fields held, `data_sel`=100.
   - 13-byte packet → DRAIN, single `pkt_err` at `eop`.
   - `rx_error` on byte 3 of a data packet → `pkt_err`.
5. **`PID_CHECK_EN` defined.** Handshake with 0xD3 → `pkt_err`. Without the macro, the same stimulus → `pkt_valid`.
6. **Back-to-back and reset.**
   - Data packet followed one cycle after `eop` by a token → two `pkt_valid` pulses, correct fields for each.
   - `rst` after 5 bytes → no pulse, outputs at reset values.
